// File: rtl/coin_uart_tx.sv
// Coin-event UART transmitter: queues coin codes in a small FIFO and sends one 8N1 byte per event.
// Latency: event accepted at edge N into an idle, empty unit -> start bit on the line after edge N+1.
// Backpressure: none upstream; an event arriving while the FIFO is full (and not popping) is dropped and sets overflow.
module coin_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coinValid,
    input  logic [1:0] coinValue,
    output logic       UART_TXD,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [15:0]      r_baud;
    logic [15:0]      w_baud_nxt;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_txd;
    logic             r_overflow;
    logic             w_txd_nxt;

    logic             w_push_req;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic             w_fifo_full;
    logic             w_bit_last;
    logic [1:0]       w_head;

    // Coin code to ASCII: 'C'ircle, 'T'riangle, 'P'entagon.
    function automatic logic [7:0] f_encode(input logic [1:0] code);
        case (code)
            2'b01:   f_encode = 8'h43;
            2'b10:   f_encode = 8'h54;
            2'b11:   f_encode = 8'h50;
            default: f_encode = 8'h00;
        endcase
    endfunction

    // A code of 00 is "no coin" and never reaches the FIFO. Pop depends only on
    // registered state, so a push into an empty FIFO can never be popped the same cycle.
    assign w_push_req  = coinValid && (coinValue != 2'b00);
    assign w_fifo_full = (r_count == CNT_FULL);
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    assign w_push      = w_push_req && (!w_fifo_full || w_pop);
    assign w_drop      = w_push_req && w_fifo_full && !w_pop;
    assign w_head      = r_mem[r_rd_ptr];
    assign w_bit_last  = (r_baud == BAUD_LAST);

    assign UART_TXD = r_txd;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);
    assign full     = w_fifo_full;
    assign overflow = r_overflow;

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: each non-idle state lasts whole bit periods; IDLE lasts at least one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_pop)                               w_state_nxt = S_START;
            S_START: if (w_bit_last)                          w_state_nxt = S_DATA;
            S_DATA:  if (w_bit_last && (r_bit_idx == 3'd7))   w_state_nxt = S_STOP;
            S_STOP:  if (w_bit_last)                          w_state_nxt = S_IDLE;
            default:                                          w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: next line level is derived from the next state so the line register changes on the transition edge.
    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = f_encode(w_head);
        end else if ((r_state == S_DATA) && w_bit_last) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end

        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // Baud counter clears on every state change and every bit boundary; bit index restarts on entry to DATA.
    always_comb begin
        w_baud_nxt    = r_baud + 16'd1;
        w_bit_idx_nxt = r_bit_idx;
        if ((w_state_nxt != r_state) || w_bit_last || (r_state == S_IDLE)) begin
            w_baud_nxt = 16'd0;
        end
        if ((r_state == S_START) && (w_state_nxt == S_DATA)) begin
            w_bit_idx_nxt = 3'd0;
        end else if ((r_state == S_DATA) && w_bit_last) begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
        end
    end

    // Transmit datapath registers, including the registered line driver.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_txd     <= 1'b1;
        end else begin
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_txd     <= w_txd_nxt;
        end
    end

    // FIFO storage; contents need no reset because the occupancy count gates every read.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= coinValue;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_coin_uart_tx.sv
module tb_coin_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       coinValid;
    logic [1:0] coinValue;
    logic       UART_TXD;
    logic       busy;
    logic       full;
    logic       overflow;

    coin_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .coinValid (coinValid),
        .coinValue (coinValue),
        .UART_TXD  (UART_TXD),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: queued codes, cycles left in the current frame, sticky overflow.
    logic [1:0] m_q[$];
    int         m_tx_left = 0;
    bit         m_ovf     = 1'b0;
    int         cyc       = 0;
    int         abort_cnt = 0;
    logic [7:0] exp_byte[$];
    int         exp_cyc[$];

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [7:0] enc(logic [1:0] c);
        case (c)
            2'd1:    return 8'h43;
            2'd2:    return 8'h54;
            2'd3:    return 8'h50;
            default: return 8'h00;
        endcase
    endfunction

    // Model: a frame occupies 10 bit periods of non-idle time, then at least one idle cycle.
    bit m_pop, m_req, m_acc;
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset) begin
                m_q.delete();
                m_tx_left = 0;
                m_ovf     = 1'b0;
                exp_byte.delete();
                exp_cyc.delete();
                abort_cnt++;
            end else begin
                m_pop = (m_tx_left == 0) && (m_q.size() > 0);
                m_req = coinValid && (coinValue != 2'b00);
                m_acc = m_req && ((m_q.size() < DEPTH) || m_pop);
                if (m_req && !m_acc) m_ovf = 1'b1;
                if (m_pop) begin
                    exp_byte.push_back(enc(m_q.pop_front()));
                    exp_cyc.push_back(cyc);
                    m_tx_left = 10 * CPB;
                end else if (m_tx_left > 0) begin
                    m_tx_left--;
                end
                if (m_acc) m_q.push_back(coinValue);
            end
            @(negedge clock);
            check("busy", busy, ((m_tx_left != 0) || (m_q.size() != 0)) ? 1 : 0);
            check("full", full, (m_q.size() == DEPTH) ? 1 : 0);
            check("overflow", overflow, m_ovf ? 1 : 0);
            if (m_tx_left == 0) check("txd_idle_high", UART_TXD, 1);
        end
    end

    // Monitor: decode frames off the line and compare against the scoreboard queue.
    int         mon_a0, mon_c0, mon_ec;
    logic [7:0] mon_got, mon_eb;
    logic       mon_stop;
    initial begin
        forever begin
            @(negedge clock);
            if (UART_TXD === 1'b0) begin
                mon_a0 = abort_cnt;
                mon_c0 = cyc;
                if (exp_byte.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got start bit at cycle %0d expected none", cyc);
                    repeat (40) @(negedge clock);
                end else begin
                    mon_eb = exp_byte.pop_front();
                    mon_ec = exp_cyc.pop_front();
                    check("frame_start_cycle", mon_c0, mon_ec);
                    repeat (CPB + 1) @(negedge clock);
                    mon_got[0] = UART_TXD;
                    for (int i = 1; i < 8; i++) begin
                        repeat (CPB) @(negedge clock);
                        mon_got[i] = UART_TXD;
                    end
                    repeat (CPB) @(negedge clock);
                    mon_stop = UART_TXD;
                    if (abort_cnt == mon_a0) begin
                        check("frame_byte", mon_got, mon_eb);
                        check("stop_bit", mon_stop, 1);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [1:0] val);
        @(negedge clock);
        coinValid = v;
        coinValue = val;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 2'b00);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clock);
        reset     = 1'b1;
        coinValid = 1'b0;
        coinValue = 2'b00;
        repeat (n - 1) @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (((m_tx_left != 0) || (m_q.size() != 0)) && (k < 3000)) begin
            @(negedge clock);
            k++;
        end
        if (k >= 3000) check({name, "_drain_timeout"}, k, 0);
        idle(5);
    endtask

    int k;
    initial begin
        reset     = 1'b1;
        coinValid = 1'b0;
        coinValue = 2'b00;
        repeat (3) @(negedge clock);
        check("reset_txd", UART_TXD, 1);
        check("reset_busy", busy, 0);
        check("reset_full", full, 0);
        check("reset_overflow", overflow, 0);
        reset = 1'b0;
        idle(2);

        // Single circle.
        drive(1'b1, 2'd1);
        idle(1);
        drain("single");

        // Ordering: triangle, pentagon, circle back to back.
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd3);
        drive(1'b1, 2'd1);
        idle(1);
        drain("order");
        check("order_overflow", overflow, 0);

        // Ignored null coins.
        repeat (10) drive(1'b1, 2'd0);
        idle(1);
        check("ignore_busy", busy, 0);
        check("ignore_txd", UART_TXD, 1);

        // Overflow burst: six pentagons.
        repeat (6) drive(1'b1, 2'd3);
        idle(1);
        check("burst_overflow", overflow, 1);
        drain("burst");
        pulse_reset(2);
        idle(2);

        // Full FIFO with push coinciding with pop.
        repeat (5) drive(1'b1, 2'd1);
        idle(1);
        check("fill_full", full, 1);
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!((m_tx_left == 0) && (m_q.size() == DEPTH)) && (k < 200));
        if (k >= 200) check("pop_wait_timeout", k, 0);
        coinValid = 1'b1;
        coinValue = 2'd1;
        idle(1);
        check("pushpop_full", full, 1);
        check("pushpop_overflow", overflow, 0);
        drain("pushpop");

        // Reset during DATA bit 3 with events queued; a coin strobed during reset is discarded.
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd3);
        idle(15);
        @(negedge clock);
        reset     = 1'b1;
        coinValid = 1'b1;
        coinValue = 2'd2;
        @(negedge clock);
        reset     = 1'b0;
        coinValid = 1'b0;
        coinValue = 2'd0;
        check("abort_txd", UART_TXD, 1);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        idle(100);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) < 2) ? 1'b1 : 1'b0, 2'($urandom_range(0, 3)));
        end
        idle(1);
        drain("random");
        idle(45);
        check("frames_outstanding", exp_byte.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_uart_tx.md
COIN_UART_TX -- requirements
Module: coin_uart_tx

Interface
- REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
- REQ-002 Parameter FIFO_DEPTH, default 4, number of queued coin events; power of two, 2..16.
- REQ-003 clock  input  1  single system clock (CLOCK_50 domain); all state updates on its rising edge.
- REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
- REQ-005 coinValid  input  1  one-cycle strobe: a coin event is presented this cycle.
- REQ-006 coinValue  input  2  coin code: 01 circle, 10 triangle, 11 pentagon, 00 none.
- REQ-007 UART_TXD  output  1  serial line, 8N1, idle high.
- REQ-008 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- REQ-009 full  output  1  high when the FIFO holds FIFO_DEPTH entries.
- REQ-010 overflow  output  1  sticky flag: an event was dropped.

Function
- REQ-011 An event is valid only when coinValid=1 and coinValue!=00; coinValue=00 with coinValid=1 is ignored and does not touch the FIFO.
- REQ-012 Byte encoding: circle 8'h43, triangle 8'h54, pentagon 8'h50; the FIFO stores the 2-bit code, and encoding happens at pop.
- REQ-013 The FIFO is first-in first-out, with circular read/write pointers and an occupancy counter of width clog2(FIFO_DEPTH)+1.
- REQ-014 Push when full and no pop in the same cycle: the event is dropped, overflow is set to 1, and FIFO contents are unchanged.
- REQ-015 Push and pop in the same cycle while full: the push is accepted and occupancy is unchanged.
- REQ-016 Push and pop in the same cycle while empty: not permitted; the pop requires non-empty, which is registered state.
- REQ-017 The FSM has four states: IDLE, START, DATA, STOP.
- REQ-018 IDLE: UART_TXD=1. If the FIFO is non-empty, pop the head, load the shift register with the encoded byte, and go to START.
- REQ-019 START: UART_TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- REQ-020 DATA: UART_TXD=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit; after bit index 7 go to STOP. Bits go out LSB first.
- REQ-021 STOP: UART_TXD=1 for CLKS_PER_BIT cycles, then go to IDLE.
- REQ-022 Back-to-back frames: from STOP to IDLE there is exactly one IDLE cycle (line high) before the next START, so each frame is 10*CLKS_PER_BIT+1 cycles.
- REQ-023 Latency: for an event accepted at edge N into an empty FIFO with the FSM in IDLE, the FIFO is non-empty after edge N, the FSM enters START at edge N+1, and UART_TXD falls after edge N+1.
- REQ-024 The baud counter counts 0..CLKS_PER_BIT-1, wraps to 0 on every bit boundary, and is cleared on entry to START.
- REQ-025 UART_TXD is driven from a register and is glitch-free.
- REQ-026 busy = (state != IDLE) or (occupancy != 0), registered-consistent with that cycle's state.
- REQ-027 full = (occupancy == FIFO_DEPTH).
- REQ-028 coinValid held high for multiple cycles is treated as one event per cycle; debouncing is the caller's responsibility.

Reset
- REQ-029 On reset: state=IDLE, UART_TXD=1, FIFO occupancy 0, both pointers 0, baud counter 0, bit index 0, overflow=0, busy=0, full=0.
- REQ-030 Reset mid-frame aborts the frame immediately; the line returns high on the next cycle and all queued events are discarded.
- REQ-031 Reset has priority over push and pop in the same cycle; a coin strobed during reset is discarded.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
- REQ-032 Single circle: strobe coinValue=01 once from idle -> UART_TXD shows 0, then 1,1,0,0,0,0,1,0 (8'h43 LSB first), then 1, each held 4 cycles; the low edge follows the strobe by 2 edges; busy is high until the stop bit completes.
- REQ-033 Ordering: strobe triangle, then pentagon, then circle on consecutive cycles -> frames 8'h54, 8'h50, 8'h43 in order, each 41 cycles apart start-to-start; overflow stays 0.
- REQ-034 Overflow: strobe 6 pentagons on consecutive cycles -> the first pops immediately, 4 queue (full=1), the 6th is dropped, overflow=1; exactly 5 frames of 8'h50 are transmitted.
- REQ-035 Ignore: coinValid=1 with coinValue=00 for 10 cycles -> UART_TXD stays 1, busy stays 0, occupancy stays 0.
- REQ-036 Reset mid-frame: assert reset during DATA bit 3 -> UART_TXD=1 the following cycle, busy=0, overflow=0, and no further frames appear.
- REQ-037 Full with simultaneous push and pop: with the FIFO full, strobe circle on the cycle the FSM pops -> the push is accepted, overflow stays 0, and full remains 1.
